// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: STEP-bit ripple slice per clock, carry held between slices,
// valid/ready handshakes on both sides.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);
    localparam int unsigned N  = WIDTH / STEP;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             carry_q;
    logic             ovf_q;
    logic [STEP-1:0]  slice_s;
    logic             slice_co;
    logic             c_msb;
    logic             last;

    // c_msb ends up as the carry into the top bit of the slice, needed for overflow.
    always_comb begin
        logic c;
        c       = c_q;
        c_msb   = c_q;
        slice_s = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            c_msb      = c;
            slice_s[i] = a_q[i] ^ b_q[i] ^ c;
            c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        slice_co = c;
    end

    // Sum assembles LSB-first: new slice enters at the top, shifting the rest down.
    assign acc_d = WIDTH'({slice_s, acc_q} >> STEP);
    assign last  = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        c_q     <= sub | cin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> STEP;
                    b_q   <= b_q >> STEP;
                    acc_q <= acc_d;
                    c_q   <= slice_co;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        sum_q   <= acc_d;
                        carry_q <= slice_co;
                        ovf_q   <= c_msb ^ slice_co;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases on an 8/1 instance, random sweeps on
// several WIDTH/STEP instances against a behavioural arithmetic model.
module tb_serial_adder;

    typedef struct {
        longint unsigned s;
        logic            c;
        logic            v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sweep_rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   sweep_done = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input int w, input longint unsigned x, input longint unsigned y,
                                   input logic ci, input logic sb);
        longint unsigned mask;
        longint unsigned yy;
        longint unsigned full;
        exp_t            r;
        mask = (64'd1 << w) - 64'd1;
        yy   = sb ? (~y & mask) : y;
        full = x + yy + (sb ? 64'd1 : {63'd0, ci});
        r.s  = full & mask;
        r.c  = full[w];
        r.v  = (x[w-1] == yy[w-1]) && (r.s[w-1] != x[w-1]);
        return r;
    endfunction

    // Directed instance, WIDTH=8 STEP=1
    logic       m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready;
    logic       m_carry, m_overflow, m_busy;
    logic [7:0] m_a, m_b, m_sum;
    exp_t       mq[$];

    serial_adder #(.WIDTH(8), .STEP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .sum(m_sum),
        .carry(m_carry), .overflow(m_overflow), .busy(m_busy)
    );

    always @(negedge clk) begin
        if (m_out_valid && m_out_ready) begin
            if (mq.size() == 0) begin
                check("m_spurious_out", m_out_valid, 0);
            end else begin
                exp_t e;
                e = mq.pop_front();
                check("m_sum", m_sum, e.s);
                check("m_carry", m_carry, e.c);
                check("m_overflow", m_overflow, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                            input logic tsub, input logic push, input exp_t e);
        int to;
        to = 0;
        while (!m_in_ready && to < 100) begin
            tick();
            to++;
        end
        check("m_drive_ready", m_in_ready, 1);
        m_a = ta; m_b = tb_; m_cin = tcin; m_sub = tsub; m_in_valid = 1'b1;
        if (push) mq.push_back(e);
        tick();
        m_in_valid = 1'b0;
        m_a = $urandom; m_b = $urandom; m_cin = $urandom; m_sub = $urandom;
    endtask

    task automatic wait_idle();
        int to;
        to = 0;
        while ((mq.size() != 0 || !m_in_ready) && to < 200) begin
            tick();
            to++;
        end
        check("m_drain", mq.size(), 0);
    endtask

    // Random sweep instances
    for (genvar k = 0; k < 5; k++) begin : g_sweep
        localparam int GW = (k == 4) ? 16 : 8;
        localparam int GS = (k == 4) ? 4 : (1 << k);

        logic          in_valid, in_ready, cin, sub, out_valid, out_ready, carry, overflow, busy;
        logic [GW-1:0] ga, gb, sum;
        exp_t          q[$];

        serial_adder #(.WIDTH(GW), .STEP(GS)) u_dut (
            .clk(clk), .rst_n(sweep_rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .a(ga), .b(gb), .cin(cin), .sub(sub),
            .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
            .carry(carry), .overflow(overflow), .busy(busy)
        );

        always @(negedge clk) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check($sformatf("sw%0d_spurious_out", k), out_valid, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check($sformatf("sw%0d_sum", k), sum, e.s);
                    check($sformatf("sw%0d_carry", k), carry, e.c);
                    check($sformatf("sw%0d_overflow", k), overflow, e.v);
                end
            end
        end

        initial begin
            int lat;
            int to;
            in_valid = 1'b0; ga = '0; gb = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
            wait (sweep_rst_n);
            tick();
            // all-ones + 1 wraps to zero with carry out, at every width
            ga = '1; gb = GW'(1); in_valid = 1'b1;
            q.push_back('{s: 64'd0, c: 1'b1, v: 1'b0});
            check($sformatf("sw%0d_ready0", k), in_ready, 1);
            tick();
            in_valid = 1'b0;
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!out_valid && lat < 64);
            check($sformatf("sw%0d_latency", k), lat, GW / GS);

            for (int i = 0; i < 1000; i++) begin
                to = 0;
                while (!in_ready && to < 200) begin
                    tick();
                    out_ready = ($urandom_range(0, 3) != 0);
                    to++;
                end
                if (to == 200) check($sformatf("sw%0d_ready_timeout", k), in_ready, 1);
                ga = GW'($urandom); gb = GW'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'b1;
                q.push_back(model(GW, ga, gb, cin, sub));
                tick();
                in_valid = 1'b0;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
            to = 0;
            while (q.size() != 0 && to < 200) begin
                tick();
                to++;
            end
            check($sformatf("sw%0d_drain", k), q.size(), 0);
            sweep_done++;
        end
    end

    initial begin
        int lat;
        int to;
        exp_t none;
        none = '{s: 64'd0, c: 1'b0, v: 1'b0};
        rst_n = 1'b0; sweep_rst_n = 1'b0;
        m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", m_in_ready, 1);
        check("rst_out_valid", m_out_valid, 0);
        check("rst_busy", m_busy, 0);
        check("rst_sum", m_sum, 0);
        check("rst_carry", m_carry, 0);
        check("rst_overflow", m_overflow, 0);
        rst_n = 1'b1; sweep_rst_n = 1'b1;
        tick();

        drive_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, '{s: 64'h96, c: 1'b0, v: 1'b1});
        check("run_busy", m_busy, 1);
        check("run_in_ready", m_in_ready, 0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!m_out_valid && lat < 64);
        check("latency8", lat, 8);
        wait_idle();

        drive_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, '{s: 64'h00, c: 1'b1, v: 1'b0});
        wait_idle();
        drive_op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, '{s: 64'h01, c: 1'b1, v: 1'b0});
        wait_idle();

        // Backpressure: result held while new operands are presented and ignored
        m_out_ready = 1'b0;
        drive_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b1, '{s: 64'hF0, c: 1'b0, v: 1'b0});
        to = 0;
        while (!m_out_valid && to < 50) begin
            tick();
            to++;
        end
        check("bp_valid", m_out_valid, 1);
        m_a = 8'h80; m_b = 8'h01; m_cin = 1'b0; m_sub = 1'b1; m_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_sum", m_sum, 8'hF0);
            check("bp_carry", m_carry, 0);
            check("bp_in_ready", m_in_ready, 0);
            check("bp_out_valid", m_out_valid, 1);
            tick();
        end
        m_out_ready = 1'b1;
        mq.push_back('{s: 64'h7F, c: 1'b1, v: 1'b1});
        tick();
        check("bp_idle_ready", m_in_ready, 1);
        check("bp_idle_valid", m_out_valid, 0);
        tick();
        check("bp_accept_busy", m_busy, 1);
        m_in_valid = 1'b0;
        wait_idle();

        // Reset in RUN cycle 4 drops the operation
        drive_op(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, none);
        repeat (4) tick();
        check("mid_busy", m_busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", m_in_ready, 1);
        check("mid_rst_out_valid", m_out_valid, 0);
        check("mid_rst_busy", m_busy, 0);
        check("mid_rst_sum", m_sum, 0);
        check("mid_rst_carry", m_carry, 0);
        check("mid_rst_overflow", m_overflow, 0);
        repeat (2) begin
            tick();
            check("mid_rst_hold_valid", m_out_valid, 0);
        end
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            check("post_rst_no_valid", m_out_valid, 0);
        end
        drive_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, '{s: 64'h02, c: 1'b0, v: 1'b0});
        wait_idle();

        to = 0;
        while (sweep_done < 5 && to < 80000) begin
            tick();
            to++;
        end
        check("sweeps_done", sweep_done, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
